// File: rtl/fifo_sp_sched_pkg.sv
// Shared types for the single-port-memory FIFO scheduler: arbiter state and
// request/grant bit positions used between the top level and the arbiter.
package fifo_sp_sched_pkg;

    typedef enum logic {
        LAST_PUSH = 1'b0,
        LAST_POP  = 1'b1
    } arb_state_e;

    localparam int unsigned REQ_PUSH = 0;
    localparam int unsigned REQ_POP  = 1;

endpackage

// File: rtl/gen_rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot grant; the requester that
// did not win last time gets priority when both ask in the same cycle.
module gen_rr_arb2
    import fifo_sp_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    arb_state_e state;
    arb_state_e state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LAST_POP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = LAST_POP;
        end else if (gnt[REQ_PUSH]) begin
            state_nxt = LAST_PUSH;
        end else if (gnt[REQ_POP]) begin
            state_nxt = LAST_POP;
        end
    end

    // clr blocks every grant so the clear cycle never touches the memory
    always_comb begin
        gnt = 2'b00;
        if (!clr) begin
            if (req[REQ_PUSH] && req[REQ_POP]) begin
                if (state == LAST_POP) begin
                    gnt[REQ_PUSH] = 1'b1;
                end else begin
                    gnt[REQ_POP] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/fifo_sp_sched.sv
// FIFO built on an external single-port memory: push and pop share the one
// memory port through a round-robin arbiter, read data returns a cycle later.
module fifo_sp_sched
    import fifo_sp_sched_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int DAT_W = 4,
    localparam int ADD_W = $clog2(DEPTH),
    localparam int CNT_W = ADD_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push_req,
    input  logic [DAT_W-1:0] push_dat,
    output logic             push_gnt,
    input  logic             pop_req,
    output logic             pop_gnt,
    output logic             pop_vld,
    output logic [DAT_W-1:0] pop_dat,
    output logic             mem_cs,
    output logic             mem_wen,
    output logic [ADD_W-1:0] mem_add,
    output logic [DAT_W-1:0] mem_dat_in,
    input  logic [DAT_W-1:0] mem_dat_out,
    output logic [CNT_W-1:0] sts_count,
    output logic             sts_full,
    output logic             sts_empty
);

    logic             push_ok;
    logic             pop_ok;
    logic [1:0]       arb_req;
    logic [1:0]       arb_gnt;
    logic [ADD_W-1:0] wr_ptr;
    logic [ADD_W-1:0] rd_ptr;
    logic             vld_p1;
    logic [DAT_W-1:0] dat_hold;

    // DEPTH need not be a power of two, so wrap explicitly
    function automatic logic [ADD_W-1:0] ptr_inc(input logic [ADD_W-1:0] ptr);
        if (ptr == ADD_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign sts_full  = (sts_count == CNT_W'(DEPTH));
    assign sts_empty = (sts_count == '0);

    assign push_ok = push_req && !sts_full;
    assign pop_ok  = pop_req && !sts_empty;

    always_comb begin
        arb_req          = 2'b00;
        arb_req[REQ_PUSH] = push_ok;
        arb_req[REQ_POP]  = pop_ok;
    end

    gen_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    assign push_gnt = arb_gnt[REQ_PUSH];
    assign pop_gnt  = arb_gnt[REQ_POP];

    always_comb begin
        mem_cs     = push_gnt || pop_gnt;
        mem_wen    = push_gnt;
        mem_add    = push_gnt ? wr_ptr : rd_ptr;
        mem_dat_in = push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sts_count <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sts_count <= '0;
        end else begin
            if (push_gnt) begin
                wr_ptr    <= ptr_inc(wr_ptr);
                sts_count <= sts_count + 1'b1;
            end
            if (pop_gnt) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                sts_count <= sts_count - 1'b1;
            end
        end
    end

    // p1: memory read data returns; a read granted just before clr still lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            dat_hold <= '0;
        end else begin
            vld_p1 <= pop_gnt;
            if (vld_p1) begin
                dat_hold <= mem_dat_out;
            end
        end
    end

    assign pop_vld = vld_p1;
    assign pop_dat = vld_p1 ? mem_dat_out : dat_hold;

endmodule

// File: doc/fifo_sp_sched.md
FIFO_SP_SCHED -- requirements
Module: fifo_sp_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; any value >= 2, power of two not required.
REQ-002 SHALL have parameter DAT_W, default 4, data width in bits.
REQ-003 SHALL have localparam ADD_W = $clog2(DEPTH), memory address width.
REQ-004 SHALL have localparam CNT_W = ADD_W+1, count width.
REQ-005 SHALL have port clk  in  1  single clock; all logic samples on posedge.
REQ-006 SHALL have port rst_n  in  1  asynchronous reset, active low.
REQ-007 SHALL have port clr  in  1  synchronous FIFO clear.
REQ-008 SHALL have port push_req  in  1  producer requests one write; held until push_gnt.
REQ-009 SHALL have port push_dat  in  DAT_W  write data, stable while push_req is high.
REQ-010 SHALL have port push_gnt  out  1  write performed this cycle.
REQ-011 SHALL have port pop_req  in  1  consumer requests one read; held until pop_gnt.
REQ-012 SHALL have port pop_gnt  out  1  read access performed this cycle.
REQ-013 SHALL have port pop_vld  out  1  pop_dat valid.
REQ-014 SHALL have port pop_dat  out  DAT_W  read data.
REQ-015 SHALL have port mem_cs  out  1  single-port memory chip-select.
REQ-016 SHALL have port mem_wen  out  1  memory write enable.
REQ-017 SHALL have port mem_add  out  ADD_W  memory address.
REQ-018 SHALL have port mem_dat_in  out  DAT_W  memory write data.
REQ-019 SHALL have port mem_dat_out  in  DAT_W  memory read data, valid the cycle after a read access.
REQ-020 SHALL have port sts_count  out  CNT_W  stored entries.
REQ-021 SHALL have port sts_full  out  1  sts_count == DEPTH.
REQ-022 SHALL have port sts_empty  out  1  sts_count == 0.

Function
REQ-023 SHALL define eligibility: push_ok = push_req & !sts_full; pop_ok = pop_req & !sts_empty.
REQ-024 SHALL grant at most one access per cycle; push_gnt and pop_gnt are combinational, same cycle as the request, and never high together.
REQ-025 SHALL grant the sole eligible requester when only one is eligible.
REQ-026 SHALL arbitrate round-robin when both are eligible, using a 2-state FSM (LAST_PUSH, LAST_POP): the requester not named by the state wins.
REQ-027 SHALL move the FSM to the winner's state on every grant and hold it when there is no grant.
REQ-028 SHALL drive the memory on push_gnt: mem_cs=1, mem_wen=1, mem_add=wr_ptr, mem_dat_in=push_dat.
REQ-029 SHALL drive the memory on pop_gnt: mem_cs=1, mem_wen=0, mem_add=rd_ptr.
REQ-030 SHALL otherwise drive mem_cs=0 and mem_wen=0.
REQ-031 SHALL assert pop_vld exactly one cycle after pop_gnt, with pop_dat = mem_dat_out; pop_dat SHALL be held between pops.
REQ-032 SHALL advance wr_ptr/rd_ptr by 1 on the respective grant, wrapping DEPTH-1 -> 0.
REQ-033 SHALL increment sts_count on push_gnt and decrement it on pop_gnt, taking effect the next cycle; sts_full and sts_empty derive from the registered count.
REQ-034 SHALL on full or empty withhold the grant silently (no error); the requester keeps waiting.
REQ-035 SHALL on clr give clr priority: no grants that cycle; next cycle pointers=0, count=0, FSM=LAST_POP.
REQ-036 SHALL still deliver a pop_vld already in flight from the cycle before clr.

Reset
REQ-037 SHALL while rst_n=0 asynchronously set wr_ptr=0, rd_ptr=0, sts_count=0, FSM=LAST_POP (push wins the first conflict), pop_vld=0, pop_dat=0.
REQ-038 SHALL give sts_empty=1 and sts_full=0 in reset; gnt and mem outputs follow the combinational rules.
REQ-039 SHALL restart cleanly on reset asserted mid-operation: in-flight reads are discarded and pop_vld stays 0.

Structure
REQ-040 SHALL place the FSM state enum (LAST_PUSH, LAST_POP) in package fifo_sp_sched_pkg.
REQ-041 SHALL implement arbitration in sub-module gen_rr_arb2: two requests in, one-hot grant out, internal state.

Verification
REQ-042 SHALL verify: push 3 values (0x1,0x2,0x3) with no pop -> 3 consecutive push_gnt; sts_count=3; mem_add 0,1,2.
REQ-043 SHALL verify: push_req and pop_req held high with count=4 -> grants alternate push,pop,push...; count oscillates 4/5; each pop_vld lags pop_gnt by 1.
REQ-044 SHALL verify: DEPTH=6, 6 pushes then continued push_req -> sts_full=1, push_gnt=0; one pop -> next push writes address 0 (wrap).
REQ-045 SHALL verify: pop_req on empty FIFO -> no pop_gnt or pop_vld; a single push -> pop granted the following cycle, pop_dat equals pushed value.
REQ-046 SHALL verify: clr in the cycle after pop_gnt with count=5 -> pop_vld still asserted; next cycle count=0, sts_empty=1; next push uses address 0.
REQ-047 SHALL verify: rst_n pulsed low mid-stream -> all outputs at reset values immediately; no pop_vld after release.
